// File: rtl/store_checker_if.sv
// rtl/store_checker_if.sv - store-bus, expected-table load and verdict signals for store_checker
//
// Purpose : bundles every non-clock, non-reset signal of store_checker.
// Ports   : master modport (bench / store-bus source) drives memwrite, dataadr,
//           writedata, exp_we, exp_addr, exp_data, exp_mode, start and observes
//           done, pass, fail_code, fail_addr, fail_data, match_count,
//           ignore_count, cycle_count. The slave modport (the checker) is the mirror.
interface store_checker_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]       memwrite;
  logic [WIDTH-1:0] dataadr;
  logic [WIDTH-1:0] writedata;

  logic             exp_we;
  logic [WIDTH-1:0] exp_addr;
  logic [WIDTH-1:0] exp_data;
  logic [1:0]       exp_mode;
  logic             start;

  logic             done;
  logic             pass;
  logic [1:0]       fail_code;
  logic [WIDTH-1:0] fail_addr;
  logic [WIDTH-1:0] fail_data;
  logic [CW-1:0]    match_count;
  logic [15:0]      ignore_count;
  logic [31:0]      cycle_count;

  modport master (
    output memwrite, dataadr, writedata,
    output exp_we, exp_addr, exp_data, exp_mode, start,
    input  done, pass, fail_code, fail_addr, fail_data,
    input  match_count, ignore_count, cycle_count
  );

  modport slave (
    input  memwrite, dataadr, writedata,
    input  exp_we, exp_addr, exp_data, exp_mode, start,
    output done, pass, fail_code, fail_addr, fail_data,
    output match_count, ignore_count, cycle_count
  );
endinterface

// File: rtl/store_checker.sv
// rtl/store_checker.sv - self-checking monitor for the pipelined MIPS store bus
//
// Purpose : holds a table of up to DEPTH expected stores, compares observed
//           stores against it (skipping IGNORE_ADDR) and reports a sticky
//           PASS/FAIL verdict with a reason code and counters.
// Ports   : clk   - clock, all state updates on posedge
//           reset - synchronous, active-high
//           bus   - store_checker_if.slave (store bus in, table load in,
//                   verdict and counters out; all outputs registered)
// Option  : STORE_CHECKER_UNORDERED_EN - match each store against any
//           unconsumed entry instead of strictly in order.
module store_checker #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 8,
  parameter int TIMEOUT      = 1000,
  parameter int IGNORE_ADDR  = 80,
  parameter int IGNORE_VALID = 1
) (
  input  logic            clk,
  input  logic            reset,
  store_checker_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] IGN_ADDR = WIDTH'(IGNORE_ADDR);
  localparam logic [31:0]      TO_LAST  = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_PASS, S_FAIL} state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] tbl_addr_q [DEPTH];
  logic [WIDTH-1:0] tbl_data_q [DEPTH];
  logic [1:0]       tbl_mode_q [DEPTH];

  logic             done_q;
  logic             pass_q;
  logic [1:0]       fail_code_q;
  logic [WIDTH-1:0] fail_addr_q;
  logic [WIDTH-1:0] fail_data_q;
  logic [CW-1:0]    match_count_q;
  logic [15:0]      ignore_count_q;
  logic [31:0]      cycle_count_q;

  logic             store_v;
  logic             ignored;
  logic             is_store;
  logic             hit;
  logic [IW-1:0]    hit_idx;
  logic             last_hit;
  logic             verdict_pass;
  logic             verdict_fail;
  logic             timed_out;

  // An X/Z strobe never looks like a store; an X/Z address is never ignored.
  assign store_v  = (bus.memwrite != 2'b00);
  assign ignored  = (IGNORE_VALID != 0) && (bus.dataadr == IGN_ADDR);
  assign is_store = store_v && !ignored;

`ifdef STORE_CHECKER_UNORDERED_EN
  logic [DEPTH-1:0] consumed_q;

  // Scan downward so the last assignment wins with the lowest-index hit.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!consumed_q[i] && (CW'(i) < count_q) &&
          ({bus.dataadr, bus.writedata, bus.memwrite} ===
           {tbl_addr_q[i], tbl_data_q[i], tbl_mode_q[i]})) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end
`else
  // In-order: only the entry at the match pointer is a candidate.
  assign hit_idx = IW'(match_count_q);
  assign hit     = ({bus.dataadr, bus.writedata, bus.memwrite} ===
                    {tbl_addr_q[hit_idx], tbl_data_q[hit_idx], tbl_mode_q[hit_idx]});
`endif

  assign last_hit     = hit && ((match_count_q + CW'(1)) == count_q);
  assign verdict_pass = (count_q == '0) || (is_store && last_hit);
  assign verdict_fail = (count_q != '0) && is_store && !hit;
  assign timed_out    = (cycle_count_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_LOAD;
      count_q        <= '0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_code_q    <= 2'd0;
      fail_addr_q    <= '0;
      fail_data_q    <= '0;
      match_count_q  <= '0;
      ignore_count_q <= '0;
      cycle_count_q  <= '0;
`ifdef STORE_CHECKER_UNORDERED_EN
      consumed_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_LOAD: begin
          // start beats a coincident push; pushes beyond DEPTH are dropped.
          if (bus.start) begin
            state_q <= S_RUN;
          end else if (bus.exp_we && (count_q != CW'(DEPTH))) begin
            tbl_addr_q[IW'(count_q)] <= bus.exp_addr;
            tbl_data_q[IW'(count_q)] <= bus.exp_data;
            tbl_mode_q[IW'(count_q)] <= bus.exp_mode;
            count_q                  <= count_q + CW'(1);
          end
        end

        S_RUN: begin
          if (store_v && ignored && (count_q != '0) && (ignore_count_q != 16'hFFFF)) begin
            ignore_count_q <= ignore_count_q + 16'd1;
          end
          if (is_store && hit && (count_q != '0)) begin
            match_count_q <= match_count_q + CW'(1);
`ifdef STORE_CHECKER_UNORDERED_EN
            consumed_q[hit_idx] <= 1'b1;
`endif
          end

          // A verdict on the threshold edge outranks the timeout.
          if (verdict_pass) begin
            state_q       <= S_PASS;
            done_q        <= 1'b1;
            pass_q        <= 1'b1;
            cycle_count_q <= cycle_count_q + 32'd1;
          end else if (verdict_fail) begin
            state_q       <= S_FAIL;
            done_q        <= 1'b1;
            fail_code_q   <= 2'd1;
            fail_addr_q   <= bus.dataadr;
            fail_data_q   <= bus.writedata;
            cycle_count_q <= cycle_count_q + 32'd1;
          end else if (timed_out) begin
            // cycle_count is left at TIMEOUT-1 so it reads back the threshold.
            state_q     <= S_FAIL;
            done_q      <= 1'b1;
            fail_code_q <= 2'd2;
          end else begin
            cycle_count_q <= cycle_count_q + 32'd1;
          end
        end

        S_PASS: begin
          if (is_store) begin
            state_q     <= S_FAIL;
            pass_q      <= 1'b0;
            fail_code_q <= 2'd3;
            fail_addr_q <= bus.dataadr;
            fail_data_q <= bus.writedata;
          end else if (store_v && (ignore_count_q != 16'hFFFF)) begin
            ignore_count_q <= ignore_count_q + 16'd1;
          end
        end

        default: begin
          // FAIL: everything frozen until reset.
        end
      endcase
    end
  end

  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.fail_code    = fail_code_q;
  assign bus.fail_addr    = fail_addr_q;
  assign bus.fail_data    = fail_data_q;
  assign bus.match_count  = match_count_q;
  assign bus.ignore_count = ignore_count_q;
  assign bus.cycle_count  = cycle_count_q;

endmodule
